// File: rtl/permute_schedule_if.sv
// Handshake/bus bundle between the encoder top, the permute sequencer and the reader.
// The pause signal exists only when PERMUTE_CTRL_PAUSE_EN is defined.
interface permute_schedule_if;
   logic       start;
   logic       abort;
`ifdef PERMUTE_CTRL_PAUSE_EN
   logic       pause;
`endif
   logic       ld;
   logic       en_cnt;
   logic [6:0] line_number;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic       busy;
   logic       done;

   modport master (
      output start, abort,
`ifdef PERMUTE_CTRL_PAUSE_EN
      output pause,
`endif
      input  ld, en_cnt, line_number, wr_en, wr_addr, busy, done
   );

   modport slave (
      input  start, abort,
`ifdef PERMUTE_CTRL_PAUSE_EN
      input  pause,
`endif
      output ld, en_cnt, line_number, wr_en, wr_addr, busy, done
   );
endinterface

// File: rtl/permute_schedule_ctrl.sv
// Permute-table sweep sequencer: LOAD / WAIT(LAT) / WRITE per line, then DONE.
// Optional freeze input enabled by PERMUTE_CTRL_PAUSE_EN.
module permute_schedule_ctrl #(
   parameter int LINES = 25,
   parameter int LAT   = 1
) (
   input logic            clk,
   input logic            rst,
   permute_schedule_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, DONE} state_t;

   localparam logic [6:0] LAST     = 7'(LINES);
   localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

   state_t     state, nxt;
   logic [3:0] cnt, nxt_cnt;
   logic [6:0] line, nxt_line;
   logic       active;
   logic       strobe_ok;
`ifdef PERMUTE_CTRL_PAUSE_EN
   logic       held, nxt_held;
`endif

   assign active          = (state == LOAD) || (state == WAIT) || (state == WRITE);
   assign bus.line_number = line;

   always_comb begin
      nxt       = state;
      nxt_cnt   = cnt;
      nxt_line  = line;
      strobe_ok = 1'b1;
`ifdef PERMUTE_CTRL_PAUSE_EN
      nxt_held  = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               nxt      = LOAD;
               nxt_line = 7'd1;
            end
         end
         LOAD: begin
            nxt_cnt = CNT_INIT;
            nxt     = (LAT > 0) ? WAIT : WRITE;
         end
         WAIT: begin
            if (cnt == 4'd0) nxt = WRITE;
            else             nxt_cnt = cnt - 4'd1;
         end
         WRITE: begin
            if (line == LAST) begin
               nxt = DONE;
            end else begin
               nxt_line = line + 7'd1;
               nxt      = LOAD;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
`ifdef PERMUTE_CTRL_PAUSE_EN
      // a strobe state left frozen is re-entered once so its strobe fires again
      if (active && bus.pause) begin
         nxt       = state;
         nxt_cnt   = cnt;
         nxt_line  = line;
         strobe_ok = 1'b0;
         nxt_held  = 1'b1;
      end else if (held && (state == LOAD || state == WRITE)) begin
         nxt      = state;
         nxt_cnt  = cnt;
         nxt_line = line;
      end
`endif
      if (active && bus.abort) begin
         nxt      = IDLE;
         nxt_cnt  = 4'd0;
         nxt_line = 7'd0;
`ifdef PERMUTE_CTRL_PAUSE_EN
         nxt_held = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         line        <= 7'd0;
         bus.ld      <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= 5'd0;
         bus.en_cnt  <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
`ifdef PERMUTE_CTRL_PAUSE_EN
         held        <= 1'b0;
`endif
      end else begin
         state      <= nxt;
         cnt        <= nxt_cnt;
         line       <= nxt_line;
         bus.ld     <= strobe_ok && (nxt == LOAD);
         bus.wr_en  <= strobe_ok && (nxt == WRITE);
         if (nxt == WRITE) bus.wr_addr <= 5'(nxt_line - 7'd1);
         bus.en_cnt <= (nxt == LOAD) || (nxt == WAIT) || (nxt == WRITE);
         bus.busy   <= (nxt != IDLE);
         bus.done   <= (nxt == DONE);
`ifdef PERMUTE_CTRL_PAUSE_EN
         held       <= nxt_held;
`endif
      end
   end

endmodule

// File: tb/tb_permute_schedule_ctrl.sv
// Bench for permute_schedule_ctrl: schedule-arithmetic model checked every cycle
// on two configurations, plus literal timing expectations from the sweep tables.
module tb_permute_schedule_ctrl;

   localparam int NA = 4, LA = 2, PA = LA + 2;
   localparam int NB = 3, LB = 0, PB = LB + 2;
`ifdef PERMUTE_CTRL_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pse_drv = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   permute_schedule_if ia ();
   permute_schedule_if ib ();

`ifdef PERMUTE_CTRL_PAUSE_EN
   assign ia.pause = pse_drv;
   assign ib.pause = 1'b0;
`endif

   permute_schedule_ctrl #(.LINES(NA), .LAT(LA)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave));
   permute_schedule_ctrl #(.LINES(NB), .LAT(LB)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave));

   typedef struct packed {
      logic       ld, wr, en, busy, done;
      logic [6:0] line;
   } exp_t;

   // t = cycles since the start edge (0 = idle); outputs follow from the schedule
   function automatic exp_t model_out(int t, int n, int p, int hold);
      exp_t e;
      e = '0;
      if (t >= 1 && t <= n * p) begin
         e.en   = 1'b1;
         e.busy = 1'b1;
         e.line = 7'((t - 1) / p + 1);
         e.ld   = ((t - 1) % p) == 0;
         e.wr   = ((t - 1) % p) == p - 1;
      end else if (t == n * p + 1) begin
         e.busy = 1'b1;
         e.done = 1'b1;
         e.line = 7'(n);
      end else begin
         e.line = 7'(hold);
      end
      return e;
   endfunction

   function automatic int next_t(int t, logic st, logic ab, logic ps,
                                 int n, int p, int lat);
      int k;
      if (t == 0) return st ? 1 : 0;
      if (t <= n * p) begin
         if (ab) return 0;
         k = (t - 1) % p;
         if (ps && k >= 1 && k <= lat) return t;
         return t + 1;
      end
      return 0;
   endfunction

   task automatic chk(string nm, int got, int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
      end
   endtask

   task automatic cmp(string tag, exp_t e, logic ld, logic wr, logic en,
                      logic busy, logic done, logic [6:0] line, logic [4:0] addr);
      chk({tag, ".ld"}, int'(ld), int'(e.ld));
      chk({tag, ".wr_en"}, int'(wr), int'(e.wr));
      chk({tag, ".en_cnt"}, int'(en), int'(e.en));
      chk({tag, ".busy"}, int'(busy), int'(e.busy));
      chk({tag, ".done"}, int'(done), int'(e.done));
      chk({tag, ".line"}, int'(line), int'(e.line));
      if (e.wr) chk({tag, ".wr_addr"}, int'(addr), int'(e.line) - 1);
   endtask

   task automatic chk_q(string nm, input int got[$], input int want[$]);
      chk({nm, ".count"}, got.size(), want.size());
      for (int i = 0; i < got.size() && i < want.size(); i++)
         chk(nm, got[i], want[i]);
   endtask

   initial begin
      int t, h, nt;
      t = 0; h = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            t = 0; h = 0;
         end else begin
            nt = next_t(t, ia.start, ia.abort, pse_drv & PAUSE_ON, NA, PA, LA);
            if (t != 0 && nt == 0) h = (t == NA * PA + 1) ? NA : 0;
            t = nt;
         end
         @(negedge clk);
         cmp("A", model_out(t, NA, PA, h), ia.ld, ia.wr_en, ia.en_cnt,
             ia.busy, ia.done, ia.line_number, ia.wr_addr);
      end
   end

   initial begin
      int t, h, nt;
      t = 0; h = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            t = 0; h = 0;
         end else begin
            nt = next_t(t, ib.start, ib.abort, 1'b0, NB, PB, LB);
            if (t != 0 && nt == 0) h = (t == NB * PB + 1) ? NB : 0;
            t = nt;
         end
         @(negedge clk);
         cmp("B", model_out(t, NB, PB, h), ib.ld, ib.wr_en, ib.en_cnt,
             ib.busy, ib.done, ib.line_number, ib.wr_addr);
      end
   end

   // start a sweep on DUT sel and record the cycles of each strobe
   task automatic run(input int sel, input int ncyc, input int hold_start,
                      input int abort_at, input int pause_at,
                      output int ldq[$], output int wrq[$], output int adq[$],
                      output int dnq[$], output int bsq[$]);
      ldq = {}; wrq = {}; adq = {}; dnq = {}; bsq = {};
      if (sel == 0) ia.start = 1'b1; else ib.start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (c >= hold_start) begin
            ia.start = 1'b0; ib.start = 1'b0;
         end
         ia.abort = (sel == 0) && (c == abort_at);
         ib.abort = (sel == 1) && (c == abort_at);
         pse_drv  = (pause_at > 0) && (c >= pause_at) && (c < pause_at + 3);
         if (sel == 0 ? ia.ld : ib.ld) ldq.push_back(c);
         if (sel == 0 ? ia.wr_en : ib.wr_en) begin
            wrq.push_back(c);
            adq.push_back(int'(sel == 0 ? ia.wr_addr : ib.wr_addr));
         end
         if (sel == 0 ? ia.done : ib.done) dnq.push_back(c);
         if (sel == 0 ? ia.busy : ib.busy) bsq.push_back(c);
      end
      ia.abort = 1'b0; ib.abort = 1'b0; pse_drv = 1'b0;
   endtask

   initial begin
      int ldq[$], wrq[$], adq[$], dnq[$], bsq[$];
      int none[$];
      none = {};
      ia.start = 1'b0; ia.abort = 1'b0;
      ib.start = 1'b0; ib.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.ld", int'(ia.ld), 0);
      chk("reset.busy", int'(ia.busy), 0);
      chk("reset.line", int'(ia.line_number), 0);
      chk("reset.wr_addr", int'(ia.wr_addr), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(0, 20, 1, 0, 0, ldq, wrq, adq, dnq, bsq);
      chk_q("A.ld_cycles", ldq, '{1, 5, 9, 13});
      chk_q("A.wr_cycles", wrq, '{4, 8, 12, 16});
      chk_q("A.wr_addrs", adq, '{0, 1, 2, 3});
      chk_q("A.done_cycle", dnq, '{17});
      chk("A.busy_cycles", bsq.size(), 17);
      chk("A.line_hold", int'(ia.line_number), NA);
      repeat (2) @(negedge clk);

      run(1, 10, 1, 0, 0, ldq, wrq, adq, dnq, bsq);
      chk_q("B.ld_cycles", ldq, '{1, 3, 5});
      chk_q("B.wr_cycles", wrq, '{2, 4, 6});
      chk_q("B.done_cycle", dnq, '{7});
      repeat (2) @(negedge clk);

      run(0, 24, 24, 0, 0, ldq, wrq, adq, dnq, bsq);
      chk_q("held.ld_cycles", ldq, '{1, 5, 9, 13, 19, 23});
      chk_q("held.done_cycle", dnq, '{17});
      repeat (20) @(negedge clk);

      run(0, 20, 1, 6, 0, ldq, wrq, adq, dnq, bsq);
      chk_q("abort.wr_cycles", wrq, '{4});
      chk_q("abort.wr_addrs", adq, '{0});
      chk_q("abort.done", dnq, none);
      chk("abort.last_busy", bsq.size() > 0 ? bsq[bsq.size() - 1] : 0, 6);
      chk("abort.line", int'(ia.line_number), 0);
      repeat (2) @(negedge clk);

      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst.ld", int'(ia.ld), 0);
      chk("arst.wr_en", int'(ia.wr_en), 0);
      chk("arst.en_cnt", int'(ia.en_cnt), 0);
      chk("arst.busy", int'(ia.busy), 0);
      chk("arst.done", int'(ia.done), 0);
      chk("arst.line", int'(ia.line_number), 0);
      chk("arst.wr_addr", int'(ia.wr_addr), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run(0, 20, 1, 0, 0, ldq, wrq, adq, dnq, bsq);
      chk_q("arst.restart_ld", ldq, '{1, 5, 9, 13});
      chk_q("arst.restart_done", dnq, '{17});
      repeat (2) @(negedge clk);

      if (PAUSE_ON) begin
         run(0, 24, 1, 0, 6, ldq, wrq, adq, dnq, bsq);
         chk_q("pause.wr_cycles", wrq, '{4, 11, 15, 19});
         chk_q("pause.wr_addrs", adq, '{0, 1, 2, 3});
         chk_q("pause.done_cycle", dnq, '{20});
         repeat (2) @(negedge clk);
      end

      for (int c = 0; c < 3000; c++) begin
         ia.start = ($urandom_range(0, 7) == 0);
         ia.abort = ($urandom_range(0, 24) == 0);
         ib.start = ($urandom_range(0, 5) == 0);
         ib.abort = ($urandom_range(0, 19) == 0);
         @(negedge clk);
      end
      ia.start = 1'b0; ia.abort = 1'b0;
      ib.start = 1'b0; ib.abort = 1'b0;
      repeat (30) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/permute_schedule_ctrl.md
# permute_schedule_ctrl

Sequencer for the permute-table datapath. It steps the 7-bit `line_number` through 1..LINES and pulses `ld` once per line. It waits the datapath's fixed read latency, then issues a one-cycle write strobe so the 25-bit permute word lands in the downstream table at address `line_number-1`. It sits between the encoder top-level start/done handshake and the permute reader.

## Interface
Parameters:
- `LINES`, default 25: number of permute lines to fetch; legal range 1..127.
- `LAT`, default 1: cycles between the `ld` pulse and valid `pout` at the reader; legal range 0..15.

Ports:
- `clk`, input, 1 bit: single system clock; all state changes on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: begin a sweep; sampled only in IDLE.
- `abort`, input, 1 bit: synchronous cancel of a running sweep.
- `pause`, input, 1 bit: freezes the sweep. Present only with `PERMUTE_CTRL_PAUSE_EN` defined.
- `ld`, output, 1 bit: one-cycle load strobe to the reader.
- `en_cnt`, output, 1 bit: high whenever the sweep is active (LOAD/WAIT/WRITE).
- `line_number`, output, 7 bits: current 1-based line index.
- `wr_en`, output, 1 bit: one-cycle strobe to capture the reader's `pout`.
- `wr_addr`, output, 5 bits: equals `line_number-1` (low 5 bits), valid while `wr_en` is high.
- `busy`, output, 1 bit: high in every state except IDLE.
- `done`, output, 1 bit: one-cycle pulse at normal completion.

## Operation
- All outputs are registered.
- On reset, every output is 0: `line_number`=0, `wr_addr`=0, and the state is IDLE.
- FSM states: IDLE, LOAD, WAIT, WRITE, DONE.
- **IDLE**
  - `start`=1 → LOAD, with `line_number`←1.
  - `start` outside IDLE is ignored; no queuing.
- **LOAD**
  - `ld`=1 for exactly this cycle.
  - Goes to WAIT if `LAT`>0, otherwise directly to WRITE.
  - The wait counter is loaded with `LAT-1`.
- **WAIT**
  - The wait counter decrements each cycle.
  - Goes to WRITE when the counter reaches 0, i.e. after exactly `LAT` WAIT cycles.
- **WRITE**
  - `wr_en`=1, `wr_addr`=`line_number-1`.
  - If `line_number`==`LINES`, go to DONE; else `line_number`+1 and go to LOAD.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
  - `line_number` holds its last value until the next start.
- `en_cnt`=1 in LOAD, WAIT and WRITE.
- **Abort**
  - `abort`=1 in LOAD, WAIT or WRITE → IDLE on the next edge; `done` is not asserted.
  - `wr_en` and `ld` are suppressed in the cycle `abort` is sampled if that cycle is their strobe cycle. The registered outputs are computed from next state, so an abort seen at edge k means no strobe after edge k.
  - `line_number` is cleared to 0.
  - `abort` in IDLE or DONE has no effect; DONE still pulses.
- `abort` and `start` together in IDLE: `start` wins (the sweep begins).
- `rst` mid-sweep: immediate return to IDLE with all outputs 0. No partial write is flagged.
- `line_number` never wraps: `LINES`≤127 and the increment only occurs when `line_number`<`LINES`.

## Timing
- Start latency: `start` sampled at edge 0 → `ld`=1 and `line_number`=1 in cycle 1.
- Cycles per line: `LAT`+2 (one LOAD, `LAT` WAIT, one WRITE).
- Total run: `done` is high in cycle `LINES`·(`LAT`+2)+1 after the start edge.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `start` is accepted in the cycle after `done`, i.e. the first IDLE cycle.
- `ld` and `wr_en` are never high in the same cycle.
- Neither `ld` nor `wr_en` stays high for two consecutive cycles.

## Configuration
- Macro `PERMUTE_CTRL_PAUSE_EN`.
- **Defined:**
  - The `pause` port exists.
  - While `pause`=1 in LOAD, WAIT or WRITE: state, wait counter and `line_number` are frozen, and `ld`/`wr_en` are forced 0.
  - On release, the frozen state re-issues its strobe on the next cycle.
  - `abort` has priority over `pause`.
  - `pause` is ignored in IDLE and DONE.
- **Undefined:** no `pause` port; the sweep always runs uninterrupted.

## Test plan
- Full sweep with `LINES`=4, `LAT`=2: pulse `start` → `ld` in cycles 1, 5, 9, 13; `wr_en` in cycles 4, 8, 12, 16 with `wr_addr` 0, 1, 2, 3; `done` in cycle 17; `busy` in cycles 1..17.
- `LAT`=0, `LINES`=3: `ld`/`wr_en` alternate every cycle → `ld` in cycles 1, 3, 5; `done` in cycle 7.
- `start` held high for the whole run → exactly one sweep; a second sweep begins only after the first IDLE cycle.
- `abort` at the cycle-6 edge (`LINES`=4, `LAT`=2): no further `wr_en` after `wr_addr`=0; `done` never asserts; `line_number`=0; `busy`=0 in cycle 7.
- `rst` asserted asynchronously mid-WAIT → all outputs 0 immediately; a subsequent `start` restarts with `line_number`=1.
- With `PERMUTE_CTRL_PAUSE_EN`: `pause` held 3 cycles during WAIT of line 2 → `done` delayed by exactly 3 cycles (cycle 20); no duplicate `wr_en` for any address.
